pll_lock_sequencer: RTL



---
 rtl/pll_lock_sequencer_if.sv | 31 +++
 rtl/pll_lock_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the rPLL lock sequencer and its surroundings.
// The sequencer uses the slave view. The PLL/controller side uses the master view.
interface pll_lock_sequencer_if;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       sys_rst;
  logic       locked;
  logic       lock_lost;
  logic [7:0] retry_count;

  modport master (
    output pll_lock,
    output relock_req,
    input  pll_reset,
    input  sys_rst,
    input  locked,
    input  lock_lost,
    input  retry_count
  );

  modport slave (
    input  pll_lock,
    input  relock_req,
    output pll_reset,
    output sys_rst,
    output locked,
    output lock_lost,
    output retry_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rPLL reset/lock sequencer: pulses PLL RESET, qualifies LOCK and then releases sys_rst.
// Define PLL_SEQ_AUTO_RECOVER_EN to re-run the sequence automatically when lock drops in RUN.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input logic                 clk,
  input logic                 rst,
  pll_lock_sequencer_if.slave seq
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  localparam int CNT_W = $clog2(max3(RESET_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_RESET_PLL = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  logic             lock_p0_q, lock_p0_d;
  logic             lock_p1_q, lock_p1_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             lock_lost_q, lock_lost_d;
  logic             lock_s;
  logic             restart;

  // Stage p0/p1: two-flop synchronizer for the asynchronous LOCK pin.
  always_comb begin
    lock_p0_d = seq.pll_lock;
    lock_p1_d = lock_p0_q;
  end

  assign lock_s = lock_p1_q;

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    if (seq.relock_req) begin
      state_d     = ST_RESET_PLL;
      retry_d     = 8'd0;
      lock_lost_d = 1'b0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RESET_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // A lock arriving on the timeout cycle still counts as a lock.
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = ST_RESET_PLL;
            retry_d = sat_inc8(retry_q);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            lock_lost_d = 1'b1;
`ifdef PLL_SEQ_AUTO_RECOVER_EN
            state_d     = ST_RESET_PLL;
`else
            state_d     = ST_RUN;
`endif
          end
        end
        default: state_d = ST_RESET_PLL;
      endcase
    end
  end

  // The counter restarts on every transition, including a relock within RESET_PLL.
  always_comb begin
    restart = seq.relock_req || (state_d != state_q);
    if (restart || (state_q == ST_RUN)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_p0_q   <= 1'b0;
      lock_p1_q   <= 1'b0;
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= 8'd0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_p0_q   <= lock_p0_d;
      lock_p1_q   <= lock_p1_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign seq.pll_reset   = (state_q == ST_RESET_PLL);
  assign seq.sys_rst     = (state_q != ST_RUN);
  assign seq.locked      = (state_q == ST_RUN);
  assign seq.lock_lost   = lock_lost_q;
  assign seq.retry_count = retry_q;

endmodule
